// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: PC select encodings, PC increment
// and the nominal 32/32 queue entry layout.
package fetch_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam int PC_INCR = 4;

    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_ADDR_W = 32;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular FIFO with synchronous flush; head read straight from storage.
// 0-cycle head latency after the push edge; overflow is excluded by the caller's credit scheme.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & ~flush_i;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // The fetch credit counts the in-flight request, so a push never meets a full queue.
    assert property (@(posedge clock) disable iff (!reset_n) !(do_push && full))
        else $error("fetch_fifo push while full");

endmodule

// File: rtl/fetch_queue.sv
// PC generation + DEPTH-entry prefetch queue; issue-to-inst_valid latency 2 cycles, 1 inst/cycle.
// Requests stop when queue+in-flight reaches DEPTH; FETCH_PERF_CNT_EN adds stall/flush counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_enable,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic [ADDR_W-1:0] pc_jump,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int USED_W  = CNT_W + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc_plus4;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              inflight_q, inflight_d;
    logic              epoch_q, epoch_d;
    logic              req_epoch_q, req_epoch_d;
    logic              active_q;
    entry_t            hold_q, hold_d;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  fifo_count;
    logic [USED_W-1:0] used;
    logic              issue;
    logic              accept;
    logic              pop;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head_entry;

    assign redirect = (pc_sel != PC_SEL_SEQ);
    assign target   = pc_sel[1] ? pc_jump : pc_branch;
    assign used     = {1'b0, fifo_count} + USED_W'(inflight_q);

    // active_q keeps requests off the bus while reset is (and has just been) asserted.
    assign issue = active_q & fetch_enable & ~redirect & (used < USED_W'(DEPTH));

    assign accept = imem_rsp_valid & inflight_q & (req_epoch_q == epoch_q) & ~redirect;
    assign push_entry.inst     = imem_rsp_data;
    assign push_entry.pc_plus4 = issued_pc_q + ADDR_W'(PC_INCR);

    assign imem_req_valid = issue;
    assign imem_addr      = pc_q;

    assign inst_valid    = ~fifo_empty;
    assign pop           = inst_valid & inst_ready;
    assign inst_data     = inst_valid ? head_entry.inst : hold_q.inst;
    assign inst_pc_plus4 = inst_valid ? head_entry.pc_plus4 : hold_q.pc_plus4;

    always_comb begin
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        hold_d      = inst_valid ? head_entry : hold_q;
        if (redirect) begin
            pc_d    = target;
            epoch_d = ~epoch_q;
        end else if (issue) begin
            pc_d        = pc_q + ADDR_W'(PC_INCR);
            issued_pc_d = pc_q;
            req_epoch_d = epoch_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            active_q    <= 1'b0;
            hold_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
            active_q    <= 1'b1;
            hold_q      <= hold_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (accept),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .flush_i    (redirect),
        .head_dat_o (head_entry),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_enable && !redirect && !issue && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] pc_branch = '0;
    logic [31:0] pc_jump = '0;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc_plus4;
    logic        inject = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_enable   (fetch_enable),
        .pc_sel         (pc_sel),
        .pc_branch      (pc_branch),
        .pc_jump        (pc_jump),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc_plus4  (inst_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory: answers every request one cycle later; inject forces a stray response.
    always @(posedge clock) begin
        imem_rsp_valid <= imem_req_valid | inject;
        imem_rsp_data  <= inject ? $urandom : (imem_addr ^ K);
    end

    // Reference model: queue of expected deliveries, PC, and one in-flight slot.
    fetch_entry_t m_q[$];
    logic [31:0]  m_pc = '0;
    logic [31:0]  m_infl_pc = '0;
    bit           m_inflight = 0;
    int unsigned  m_stall = 0;
    int unsigned  m_flush = 0;

    function automatic bit exp_req();
        return fetch_enable && (pc_sel == 2'b00) && ((m_q.size() + int'(m_inflight)) < DEPTH);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_pc       = 32'h0;
            m_inflight = 0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            bit rq;
            rq = exp_req();
            if (pc_sel != 2'b00) begin
                m_q.delete();
                m_pc       = pc_sel[1] ? pc_jump : pc_branch;
                m_inflight = 0;
                m_flush++;
            end else begin
                if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
                if (imem_rsp_valid && m_inflight)
                    m_q.push_back(fetch_entry_t'{inst: imem_rsp_data, pc_plus4: m_infl_pc + 32'd4});
                if (rq) begin
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
                if (fetch_enable && !rq) m_stall++;
                m_inflight = rq;
            end
        end
    end

    task automatic do_reset();
        fetch_enable = 1'b0;
        pc_sel       = 2'b00;
        inject       = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_valid(input int budget);
        for (int k = 0; k < budget && !inst_valid; k++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n      = 1'b0;
        fetch_enable = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", inst_data); end
        checks++; if (inst_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h want=0", inst_pc_plus4); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall got=%0d want=0", perf_stall_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        fetch_enable = 1'b1;
        inst_ready   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                failures++; $display("FAIL seq_req[%0d] got=%b/%h want=1/%h", i, imem_req_valid, imem_addr, 32'(4 * i));
            end
            checks++; if (inst_valid !== (i >= 2)) begin
                failures++; $display("FAIL seq_valid[%0d] got=%b want=%b", i, inst_valid, (i >= 2));
            end
            if (i >= 2) begin
                checks++; if (inst_pc_plus4 !== 32'(4 * (i - 1)) || inst_data !== (32'(4 * (i - 2)) ^ K)) begin
                    failures++; $display("FAIL seq_head[%0d] got=%h/%h want=%h/%h", i, inst_pc_plus4, inst_data, 32'(4 * (i - 1)), 32'(4 * (i - 2)) ^ K);
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_full_queue();
        int nreq;
        do_reset();
        fetch_enable = 1'b1;
        inst_ready   = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req_valid) nreq++;
            @(negedge clock);
        end
        #1;
        checks++; if (nreq != DEPTH) begin failures++; $display("FAIL full_nreq got=%0d want=%0d", nreq, DEPTH); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL full_req got=%b want=0", imem_req_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall_cnt !== 32'd6) begin failures++; $display("FAIL full_stall_cnt got=%0d want=6", perf_stall_cnt); end
`endif
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'(4 * (k + 1)) || inst_data !== (32'(4 * k) ^ K)) begin
                failures++; $display("FAIL full_drain[%0d] got=%b/%h/%h want=1/%h/%h", k, inst_valid, inst_pc_plus4, inst_data, 32'(4 * (k + 1)), 32'(4 * k) ^ K);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_branch();
        do_reset();
        fetch_enable = 1'b1;
        inst_ready   = 1'b1;
        repeat (3) @(negedge clock);
        pc_sel    = 2'b01;
        pc_branch = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL br_req_in_redirect got=%b want=0", imem_req_valid); end
        @(negedge clock);
        pc_sel = 2'b00;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL br_flush got=%b want=0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            failures++; $display("FAIL br_target got=%b/%h want=1/00000100", imem_req_valid, imem_addr);
        end
        wait_valid(10);
        checks++; if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h104 || inst_data !== (32'h100 ^ K)) begin
            failures++; $display("FAIL br_deliver got=%b/%h/%h want=1/00000104/%h", inst_valid, inst_pc_plus4, inst_data, 32'h100 ^ K);
        end
        @(negedge clock);
    endtask

    task automatic test_jump_priority();
        pc_sel    = 2'b11;
        pc_jump   = 32'h40;
        pc_branch = 32'h80;
        @(negedge clock);
        pc_sel = 2'b00;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
            failures++; $display("FAIL jump_target got=%b/%h want=1/00000040", imem_req_valid, imem_addr);
        end
        wait_valid(10);
        checks++; if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h44) begin
            failures++; $display("FAIL jump_deliver got=%b/%h want=1/00000044", inst_valid, inst_pc_plus4);
        end
        @(negedge clock);
    endtask

    task automatic test_wrap();
        pc_sel  = 2'b10;
        pc_jump = 32'hFFFF_FFF8;
        @(negedge clock);
        pc_sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFF8 + 32'(4 * i)) begin
                failures++; $display("FAIL wrap_req[%0d] got=%b/%h want=1/%h", i, imem_req_valid, imem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            end
            if (i < 2) @(negedge clock);
        end
        wait_valid(10);
        checks++; if (inst_pc_plus4 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc4_a got=%h want=fffffffc", inst_pc_plus4); end
        @(negedge clock);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h0 || inst_data !== (32'hFFFF_FFFC ^ K)) begin
            failures++; $display("FAIL wrap_pc4_b got=%b/%h/%h want=1/00000000/%h", inst_valid, inst_pc_plus4, inst_data, 32'hFFFF_FFFC ^ K);
        end
        @(negedge clock);
    endtask

    task automatic test_fetch_disable();
        logic [31:0] last_pc4;
        fetch_enable = 1'b1;
        inst_ready   = 1'b0;
        @(negedge clock);
        fetch_enable = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL fe_low_req got=%b want=0", imem_req_valid); end
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clock);
        #1;
        checks++; if (inst_valid !== 1'b0 || m_q.size() != 0) begin
            failures++; $display("FAIL fe_low_drain got=%b want=0", inst_valid);
        end
        last_pc4 = inst_pc_plus4;
        inject = 1'b1;
        @(negedge clock);
        inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++; if (inst_valid !== 1'b0 || inst_pc_plus4 !== last_pc4) begin
                failures++; $display("FAIL spurious[%0d] got=%b/%h want=0/%h", i, inst_valid, inst_pc_plus4, last_pc4);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_enable = 1'b1;
        inst_ready   = 1'b0;
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n      = 1'b0;
        fetch_enable = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc_plus4 !== 32'h0) begin
            failures++; $display("FAIL rstmid_outputs got=%b/%b/%h/%h want=0/0/0/0", imem_req_valid, inst_valid, inst_data, inst_pc_plus4);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        fetch_enable = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b want=0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL rstmid_restart got=%b/%h want=1/00000000", imem_req_valid, imem_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) begin
                pc_sel    = 2'($urandom_range(3, 1));
                pc_branch = $urandom & 32'hFFFF_FFFC;
                pc_jump   = ($urandom_range(1) == 1) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            end else begin
                pc_sel = 2'b00;
            end
            fetch_enable = ($urandom_range(3) != 0);
            inst_ready   = ($urandom_range(2) != 0);
            #1;
            checks++; if (imem_req_valid !== exp_req()) begin
                failures++; $display("FAIL rnd_req[%0d] got=%b want=%b", i, imem_req_valid, exp_req());
            end
            if (exp_req()) begin
                checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr[%0d] got=%h want=%h", i, imem_addr, m_pc); end
            end
            checks++; if (inst_valid !== (m_q.size() > 0)) begin
                failures++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, inst_valid, (m_q.size() > 0));
            end
            if (m_q.size() > 0) begin
                checks++; if (inst_data !== m_q[0].inst || inst_pc_plus4 !== m_q[0].pc_plus4) begin
                    failures++; $display("FAIL rnd_head[%0d] got=%h/%h want=%h/%h", i, inst_data, inst_pc_plus4, m_q[0].inst, m_q[0].pc_plus4);
                end
            end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (perf_stall_cnt !== 32'(m_stall) || perf_flush_cnt !== 32'(m_flush)) begin
                failures++; $display("FAIL rnd_perf[%0d] got=%0d/%0d want=%0d/%0d", i, perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
            end
`endif
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_queue();
        test_branch();
        test_jump_priority();
        test_wrap();
        test_fetch_disable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
